alu: RTL and testbench
======================

# alu

Registered 32-bit integer ALU executing the RV32I I-type arithmetic, logical and shift-immediate operations. It sits in the execute stage after instruction decode. One-hot operation enables come from the decoder; `rd_data` comes from the register file read port; `imm` is the raw 12-bit immediate field. The result is registered and fed to writeback.

## Interface
- No parameters; data width fixed at 32, immediate width fixed at 12.
- Port order is exactly as listed below: clk, rst, the seven enables, rd_data, imm, alu_out, out_valid, sel_err.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addi_en`  in  1  select ADDI.
- `ori_en`  in  1  select ORI.
- `xori_en`  in  1  select XORI.
- `andi_en`  in  1  select ANDI.
- `slli_en`  in  1  select SLLI.
- `srli_en`  in  1  select SRLI.
- `srai_en`  in  1  select SRAI.
- `rd_data`  in  32  source operand (rs1 value).
- `imm`  in  12  raw I-type immediate.
- `alu_out`  out  32  registered result.
- `out_valid`  out  1  high for the cycle after a cycle in which at least one enable was sampled high.
- `sel_err`  out  1  registered flag: more than one enable was sampled high. Only active when the check is compiled in.

## Operation
- `simm` = `imm` sign-extended to 32 bits (bit 11 replicated). `shamt` = `imm[4:0]`; `imm[11:5]` is ignored for shifts.
- ADDI: `rd_data + simm`, modulo 2^32. No carry or overflow output.
- ORI: `rd_data | simm`.
- XORI: `rd_data ^ simm`.
- ANDI: `rd_data & simm`.
- SLLI: `rd_data << shamt`, zero fill.
- SRLI: `rd_data >> shamt`, zero fill.
- SRAI: `rd_data >>> shamt`, fill with `rd_data[31]`.
- No enable high:
  - `out_valid` = 0.
  - `alu_out` holds its previous value.
- Several enables high: fixed priority addi > ori > xori > andi > slli > srli > srai, unless overridden by the Configuration section.
- `out_valid` = 1 whenever any enable is high, including the multi-enable case.

## Timing
- Latency is one cycle. Inputs sampled at rising edge N appear on `alu_out`/`out_valid`/`sel_err` after edge N and stay stable until edge N+1.
- Throughput is one operation per cycle; no stalls and no handshake.
- Reset:
  - While `rst` is high, `alu_out` = 0, `out_valid` = 0 and `sel_err` = 0, regardless of `clk`.
  - Reset asserted mid-operation discards the pending result immediately.
  - The first operation after deassertion is sampled on the first rising edge with `rst` low.
- Enables or operands changing between edges have no effect on the outputs until the next edge.

## Configuration
- `ALU_ONEHOT_CHECK_EN` defined:
  - When two or more enables are sampled high, the next-cycle `sel_err` = 1 and `alu_out` = 0.
  - `out_valid` still = 1 in that case.
  - `sel_err` = 0 otherwise.
- `ALU_ONEHOT_CHECK_EN` undefined:
  - `sel_err` is tied to 0.
  - Multi-enable input resolves by the fixed priority above.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `alu_out` = 0, `out_valid` = 0 and `sel_err` = 0 immediately. After release with no enables, the outputs stay 0.
- Each op, one per cycle, with `rd_data` = 10, `imm` = 2 -> `alu_out` sequence 12, 10, 8, 2, 40, 2, 2, each one cycle after its enable, with `out_valid` = 1.
- Sign extension, with `rd_data` = 10 and `imm` = 0xFFF:
  - ADDI -> 9.
  - ANDI -> 10.
  - ORI -> 0xFFFFFFFF.
  - XORI -> 0xFFFFFFF5.
- Shifts, with `rd_data` = 0x80000000 and `imm` = 0x404 (imm[11:5] nonzero, so it must be ignored):
  - SRAI -> 0xF8000000.
  - SRLI -> 0x08000000.
  - SLLI -> 0x00000000.
- Idle hold: ADDI producing 12, then all enables low for 3 cycles -> `alu_out` stays 12 and `out_valid` = 0.
- Multi-enable: `addi_en` = `xori_en` = 1, `rd_data` = 10, `imm` = 2:
  - With `ALU_ONEHOT_CHECK_EN` -> `sel_err` = 1, `alu_out` = 0.
  - Without it -> `alu_out` = 12, `sel_err` = 0.

Source files
------------

// File: rtl/alu.sv
// Registered RV32I I-type ALU (ADDI/ORI/XORI/ANDI/SLLI/SRLI/SRAI), one-cycle latency.
// Optional multi-enable detection is compiled in with `define ALU_ONEHOT_CHECK_EN.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        addi_en,
    input  logic        ori_en,
    input  logic        xori_en,
    input  logic        andi_en,
    input  logic        slli_en,
    input  logic        srli_en,
    input  logic        srai_en,
    input  logic [31:0] rd_data,
    input  logic [11:0] imm,
    output logic [31:0] alu_out,
    output logic        out_valid,
    output logic        sel_err
);

    logic [31:0] w_simm;
    logic [4:0]  w_shamt;
    logic [6:0]  w_en;
    logic        w_any;
    logic [31:0] w_add;
    logic [31:0] w_or;
    logic [31:0] w_xor;
    logic [31:0] w_and;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [31:0] w_prio;
    logic [31:0] w_result;

    logic [31:0] r_alu_out;
    logic        r_out_valid;

    assign w_simm  = {{20{imm[11]}}, imm};
    assign w_shamt = imm[4:0];
    assign w_en    = {addi_en, ori_en, xori_en, andi_en, slli_en, srli_en, srai_en};
    assign w_any   = |w_en;

    assign w_add = rd_data + w_simm;
    assign w_or  = rd_data | w_simm;
    assign w_xor = rd_data ^ w_simm;
    assign w_and = rd_data & w_simm;
    assign w_sll = rd_data << w_shamt;
    assign w_srl = rd_data >> w_shamt;
    assign w_sra = $unsigned($signed(rd_data) >>> w_shamt);

    // Fixed priority resolves overlapping enables, addi highest.
    always_comb begin
        w_prio = 32'd0;
        if (addi_en)      w_prio = w_add;
        else if (ori_en)  w_prio = w_or;
        else if (xori_en) w_prio = w_xor;
        else if (andi_en) w_prio = w_and;
        else if (slli_en) w_prio = w_sll;
        else if (srli_en) w_prio = w_srl;
        else if (srai_en) w_prio = w_sra;
    end

`ifdef ALU_ONEHOT_CHECK_EN
    logic w_multi;
    logic r_sel_err;

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi  = |(w_en & (w_en - 7'd1));
    assign w_result = w_multi ? 32'd0 : w_prio;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_multi;
        end
    end

    assign sel_err = r_sel_err;
`else
    assign w_result = w_prio;
    assign sel_err  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_out   <= 32'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_alu_out <= w_result;
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; expectations are hand-computed constants.
// Build with +define+ALU_ONEHOT_CHECK_EN to exercise the multi-enable error path.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        addi_en, ori_en, xori_en, andi_en, slli_en, srli_en, srai_en;
    logic [31:0] rd_data;
    logic [11:0] imm;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        sel_err;

    int vectors     = 0;
    int miscompares = 0;

    alu dut (
        .clk       (clk),
        .rst       (rst),
        .addi_en   (addi_en),
        .ori_en    (ori_en),
        .xori_en   (xori_en),
        .andi_en   (andi_en),
        .slli_en   (slli_en),
        .srli_en   (srli_en),
        .srai_en   (srai_en),
        .rd_data   (rd_data),
        .imm       (imm),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .sel_err   (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // en order: addi ori xori andi slli srli srai
    task automatic drive(input logic [6:0] en, input logic [31:0] d, input logic [11:0] i);
        {addi_en, ori_en, xori_en, andi_en, slli_en, srli_en, srai_en} = en;
        rd_data = d;
        imm     = i;
    endtask

    task automatic step(input logic [6:0] en, input logic [31:0] d, input logic [11:0] i);
        drive(en, d, i);
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input logic [6:0] en, input logic [31:0] d,
                      input logic [11:0] i, input logic [31:0] exp);
        step(en, d, i);
        chk({tag, ".out"}, alu_out, exp);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".err"}, {31'd0, sel_err}, 32'd0);
    endtask

    localparam logic [6:0] ADDI = 7'b1000000;
    localparam logic [6:0] ORI  = 7'b0100000;
    localparam logic [6:0] XORI = 7'b0010000;
    localparam logic [6:0] ANDI = 7'b0001000;
    localparam logic [6:0] SLLI = 7'b0000100;
    localparam logic [6:0] SRLI = 7'b0000010;
    localparam logic [6:0] SRAI = 7'b0000001;
    localparam logic [6:0] NONE = 7'b0000000;

    initial begin
        rst = 1'b1;
        drive(NONE, 32'd0, 12'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out", alu_out, 32'd0);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.err", {31'd0, sel_err}, 32'd0);
        rst = 1'b0;

        op("addi", ADDI, 32'd10, 12'd2, 32'd12);
        op("ori",  ORI,  32'd10, 12'd2, 32'd10);
        op("xori", XORI, 32'd10, 12'd2, 32'd8);
        op("andi", ANDI, 32'd10, 12'd2, 32'd2);
        op("slli", SLLI, 32'd10, 12'd2, 32'd40);
        op("srli", SRLI, 32'd10, 12'd2, 32'd2);
        op("srai", SRAI, 32'd10, 12'd2, 32'd2);

        op("addi_sx", ADDI, 32'd10, 12'hFFF, 32'd9);
        op("andi_sx", ANDI, 32'd10, 12'hFFF, 32'd10);
        op("ori_sx",  ORI,  32'd10, 12'hFFF, 32'hFFFF_FFFF);
        op("xori_sx", XORI, 32'd10, 12'hFFF, 32'hFFFF_FFF5);
        op("addi_neg", ADDI, 32'd0, 12'h800, 32'hFFFF_F800);

        op("srai_hi", SRAI, 32'h8000_0000, 12'h404, 32'hF800_0000);
        op("srli_hi", SRLI, 32'h8000_0000, 12'h404, 32'h0800_0000);
        op("slli_hi", SLLI, 32'h8000_0000, 12'h404, 32'h0000_0000);
        op("slli_31", SLLI, 32'h0000_0003, 12'h01F, 32'h8000_0000);
        op("srai_pos", SRAI, 32'h7000_0000, 12'h01C, 32'h0000_0007);

        op("addi_hold", ADDI, 32'd10, 12'd2, 32'd12);
        for (int k = 0; k < 3; k++) begin
            step(NONE, 32'hDEAD_BEEF, 12'h123);
            chk("idle.out", alu_out, 32'd12);
            chk("idle.valid", {31'd0, out_valid}, 32'd0);
        end

        // Inputs changing between edges must not reach the outputs.
        drive(XORI, 32'd10, 12'd2);
        #2;
        chk("midcycle.out", alu_out, 32'd12);
        chk("midcycle.valid", {31'd0, out_valid}, 32'd0);

        step(ADDI | XORI, 32'd10, 12'd2);
`ifdef ALU_ONEHOT_CHECK_EN
        chk("multi.out", alu_out, 32'd0);
        chk("multi.err", {31'd0, sel_err}, 32'd1);
`else
        chk("multi.out", alu_out, 32'd12);
        chk("multi.err", {31'd0, sel_err}, 32'd0);
`endif
        chk("multi.valid", {31'd0, out_valid}, 32'd1);

        step(ORI | XORI, 32'd10, 12'd2);
`ifdef ALU_ONEHOT_CHECK_EN
        chk("ori_xori.out", alu_out, 32'd0);
`else
        chk("ori_xori.out", alu_out, 32'd10);
`endif
        step(ANDI | SLLI, 32'd10, 12'd2);
`ifdef ALU_ONEHOT_CHECK_EN
        chk("andi_slli.out", alu_out, 32'd0);
`else
        chk("andi_slli.out", alu_out, 32'd2);
`endif
        step(SRLI | SRAI, 32'h8000_0000, 12'h004);
`ifdef ALU_ONEHOT_CHECK_EN
        chk("srli_srai.out", alu_out, 32'd0);
`else
        chk("srli_srai.out", alu_out, 32'h0800_0000);
`endif
        step(SLLI | SRAI, 32'h8000_0000, 12'h004);
`ifdef ALU_ONEHOT_CHECK_EN
        chk("slli_srai.err", {31'd0, sel_err}, 32'd1);
`else
        chk("slli_srai.out", alu_out, 32'h0000_0000);
`endif

        op("single_after_multi", SRAI, 32'h8000_0000, 12'h004, 32'hF800_0000);

        // Reset mid-cycle with a pending operation on the inputs.
        drive(ADDI, 32'd100, 12'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst.out", alu_out, 32'd0);
        chk("async_rst.valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst.err", {31'd0, sel_err}, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held.out", alu_out, 32'd0);
        drive(NONE, 32'd100, 12'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step(NONE, 32'd100, 12'd1);
            chk("post_rst.out", alu_out, 32'd0);
            chk("post_rst.valid", {31'd0, out_valid}, 32'd0);
        end
        op("post_rst_addi", ADDI, 32'd100, 12'd1, 32'd101);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
